// File: rtl/dram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : dram_port_arbiter
// Shares one DRAM controller among NREQ ports; round-robin by default,
// fixed priority (lowest index wins) when DRAM_ARB_FIXED_PRIO_EN is defined.
// Rev    : 1.0
// ============================================================================
module dram_port_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 18,
  parameter int DW   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic [AW-1:0]      mem_addr,
  output logic               mem_write,
  output logic               mem_ena,
  input  logic               mem_busy,
  input  logic               mem_ack,
  input  logic [DW-1:0]      mem_rd_data,
  output logic [DW-1:0]      mem_wdata,
  output logic               mem_wdata_oe
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] winner;
  logic [PW-1:0] grant;
  logic          issue;
  logic          accept;
  logic          complete;

  // The controller keeps a stale ack while idle and shows busy without ack
  // while refreshing, so only busy and ack together mean "accepted".
  assign issue    = (state == S_IDLE) && !mem_busy && (|req_valid);
  assign accept   = (state == S_ISSUE) && mem_busy && mem_ack;
  assign complete = (state == S_WAIT_DONE) && !mem_busy;

`ifdef DRAM_ARB_FIXED_PRIO_EN
  always_comb begin
    winner = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) winner = PW'(i);
    end
  end
`else
  logic [PW-1:0] rr_ptr;

  // Search starts just after the last winner and wraps modulo NREQ.
  always_comb begin
    logic found;
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && req_valid[(int'(rr_ptr) + k) % NREQ]) begin
        winner = PW'((int'(rr_ptr) + k) % NREQ);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= PW'(NREQ - 1);
    end else if (issue) begin
      rr_ptr <= winner;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (issue)    state_nxt = S_ISSUE;
      S_ISSUE:     if (accept)   state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (complete) state_nxt = S_DONE;
      S_DONE:                    state_nxt = S_IDLE;
      default:                   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant        <= '0;
      req_ready    <= '0;
      rsp_valid    <= '0;
      rsp_rdata    <= '0;
      mem_addr     <= '0;
      mem_write    <= 1'b0;
      mem_ena      <= 1'b0;
      mem_wdata    <= '0;
      mem_wdata_oe <= 1'b0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      if (issue) begin
        grant        <= winner;
        mem_addr     <= req_addr[int'(winner)*AW +: AW];
        mem_write    <= req_write[winner];
        mem_wdata    <= req_wdata[int'(winner)*DW +: DW];
        mem_ena      <= 1'b1;
        mem_wdata_oe <= req_write[winner];
        req_ready    <= ONE_HOT0 << winner;
      end
      if (accept) begin
        mem_ena <= 1'b0;
      end
      if (complete) begin
        if (!mem_write) rsp_rdata <= mem_rd_data;
        rsp_valid    <= ONE_HOT0 << grant;
        mem_wdata_oe <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_dram_port_arbiter
// Directed bench for dram_port_arbiter with a behavioural DRAM controller.
// Rev    : 1.0
// ============================================================================
module tb_dram_port_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 18;
  localparam int DW   = 4;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;
  logic [AW-1:0]      mem_addr;
  logic               mem_write;
  logic               mem_ena;
  logic               mem_busy;
  logic               mem_ack;
  logic [DW-1:0]      mem_rd_data;
  logic [DW-1:0]      mem_wdata;
  logic               mem_wdata_oe;

  dram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .mem_addr     (mem_addr),
    .mem_write    (mem_write),
    .mem_ena      (mem_ena),
    .mem_busy     (mem_busy),
    .mem_ack      (mem_ack),
    .mem_rd_data  (mem_rd_data),
    .mem_wdata    (mem_wdata),
    .mem_wdata_oe (mem_wdata_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         port;
    bit         wr;
    logic [3:0] rdata;
  } rsp_t;

  rsp_t       sb[$];
  int         gq[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] clr_mask = '0;
  logic [3:0] keep_mask = '0;
  logic [3:0] last_rd = '0;
  bit         outstanding = 1'b0;
  logic       grant_edge_busy = 1'b0;

  // Controller model knobs (written by stimulus, read by the model).
  int m_delay   = 0;
  int m_refresh = 0;
  int m_lat     = 2;

  logic [17:0] last_wr_addr = '0;
  logic [3:0]  last_wr_data = '0;

  function automatic logic [3:0] rd_fn(input logic [17:0] a);
    return a[3:0] ^ a[7:4];
  endfunction

  // Behavioural controller: optional idle delay with stale ack, optional
  // refresh (busy without ack), then accept (busy+ack) and m_lat busy cycles.
  initial begin
    int          ms;
    int          mcnt;
    bit          go;
    bit          acc;
    logic [17:0] a_q;
    logic        w_q;
    logic [3:0]  d_q;
    ms = 0; mcnt = 0; a_q = '0; w_q = 1'b0; d_q = '0;
    mem_busy = 1'b0; mem_ack = 1'b0; mem_rd_data = '0;
    forever begin
      @(negedge clk);
      go = 1'b0; acc = 1'b0;
      case (ms)
        0: if (mem_ena === 1'b1) begin
             if (m_delay > 0) begin mcnt = m_delay; ms = 1; end
             else go = 1'b1;
           end
        1: begin mcnt--; if (mcnt == 0) go = 1'b1; end
        2: begin mcnt--; if (mcnt == 0) acc = 1'b1; end
        default: begin
          mcnt--;
          if (mcnt == 0) begin
            mem_busy = 1'b0;
            if (!w_q) mem_rd_data = rd_fn(a_q);
            else begin last_wr_addr = a_q; last_wr_data = d_q; end
            ms = 0;
          end
        end
      endcase
      if (go) begin
        if (m_refresh > 0) begin
          mem_busy = 1'b1; mem_ack = 1'b0; mcnt = m_refresh; ms = 2;
        end else acc = 1'b1;
      end
      if (acc) begin
        mem_busy = 1'b1; mem_ack = 1'b1;
        a_q = mem_addr; w_q = mem_write; d_q = mem_wdata;
        mcnt = m_lat; ms = 3;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_rsp(input int p, input bit w, input logic [3:0] d);
    rsp_t e;
    e.port = p; e.wr = w; e.rdata = d;
    sb.push_back(e);
  endtask

  task automatic set_req(input int p, input bit w, input logic [17:0] a, input logic [3:0] d);
    req_addr[p*AW +: AW]  = a;
    req_wdata[p*DW +: DW] = d;
    req_write[p]          = w;
    req_valid[p]          = 1'b1;
  endtask

  // One clock: sample away from the edge and score grants/responses.
  task automatic step();
    logic       b;
    logic [3:0] oh;
    rsp_t       e;
    int         g;
    @(posedge clk);
    b = mem_busy;
    #1;
    req_valid = req_valid & ~clr_mask;
    clr_mask  = '0;
    if (req_ready !== '0) begin
      grant_edge_busy = b;
      if (gq.size() == 0) chk("unexpected_grant", 32'(req_ready), 32'(0));
      else begin
        g  = gq.pop_front();
        oh = 4'b0001 << g;
        chk("grant_port", 32'(req_ready), 32'(oh));
      end
      chk("grant_while_outstanding", 32'(outstanding), 32'(0));
      chk("ready_rsp_overlap", 32'(rsp_valid), 32'(0));
      outstanding = 1'b1;
      clr_mask    = req_ready & ~keep_mask;
    end
    if (rsp_valid !== '0) begin
      if (sb.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 32'(0));
      else begin
        e  = sb.pop_front();
        oh = 4'b0001 << e.port;
        chk("rsp_port", 32'(rsp_valid), 32'(oh));
        if (!e.wr) begin
          chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
          last_rd = e.rdata;
        end else begin
          chk("rsp_rdata_hold", 32'(rsp_rdata), 32'(last_rd));
        end
      end
      outstanding = 1'b0;
    end
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 200 && (gq.size() > 0 || sb.size() > 0); i++) step();
    chk(tag, 32'(gq.size() + sb.size()), 32'(0));
    step();
    step();
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    repeat (3) step();
    chk("reset_ctrl_outputs", 32'({mem_addr, mem_write, mem_ena, mem_wdata, mem_wdata_oe}), 32'(0));
    chk("reset_port_outputs", 32'({req_ready, rsp_valid, rsp_rdata}), 32'(0));
    rst = 1'b0;
    repeat (2) step();

    // Single read on port 2.
    m_delay = 0; m_refresh = 0; m_lat = 2;
    set_req(2, 1'b0, 18'h1A5F3, 4'h0);
    gq.push_back(2);
    push_rsp(2, 1'b0, 4'hC);
    step();
    chk("rd_ready_latency", 32'(req_ready), 32'(4'b0100));
    chk("rd_issue", 32'({mem_ena, mem_write, mem_wdata_oe, mem_addr}), 32'({1'b1, 1'b0, 1'b0, 18'h1A5F3}));
    step();
    chk("rd_ena_after_accept", 32'(mem_ena), 32'(0));
    step();
    step();
    chk("rd_rsp_timing", 32'(rsp_valid), 32'(4'b0100));
    wait_drain("rd_drain");

    // Single write on port 0.
    set_req(0, 1'b1, 18'h00010, 4'h5);
    gq.push_back(0);
    push_rsp(0, 1'b1, 4'h0);
    step();
    chk("wr_issue", 32'({mem_ena, mem_write, mem_wdata_oe, mem_wdata, mem_addr}),
        32'({1'b1, 1'b1, 1'b1, 4'h5, 18'h00010}));
    step();
    step();
    chk("wr_hold", 32'({mem_write, mem_wdata_oe, mem_wdata, mem_addr}), 32'({1'b1, 1'b1, 4'h5, 18'h00010}));
    step();
    chk("wr_oe_cleared", 32'(mem_wdata_oe), 32'(0));
    chk("wr_data_at_ctrl", 32'({last_wr_addr, last_wr_data}), 32'({18'h00010, 4'h5}));
    wait_drain("wr_drain");

    // Stale ack: controller idle with ack still high must not count.
    m_delay = 3;
    set_req(1, 1'b0, 18'h20034, 4'h0);
    gq.push_back(1);
    push_rsp(1, 1'b0, 4'h7);
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stale_ack_hold_ena", 32'(mem_ena), 32'(1));
    end
    step();
    chk("stale_ack_accept", 32'(mem_ena), 32'(0));
    wait_drain("stale_drain");
    m_delay = 0;

    // Refresh collision: busy without ack must not count.
    m_refresh = 3;
    set_req(3, 1'b0, 18'h3BC9A, 4'h0);
    gq.push_back(3);
    push_rsp(3, 1'b0, 4'h3);
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("refresh_hold_ena", 32'(mem_ena), 32'(1));
    end
    step();
    chk("refresh_accept", 32'(mem_ena), 32'(0));
    wait_drain("refresh_drain");
    m_refresh = 0;

    // All four ports requesting continuously from reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    last_rd = '0; outstanding = 1'b0;
    keep_mask = 4'hF;
    set_req(0, 1'b0, 18'h000E1, 4'h0);
    set_req(1, 1'b1, 18'h00200, 4'hA);
    set_req(2, 1'b0, 18'h00456, 4'h0);
    set_req(3, 1'b0, 18'h0789C, 4'h0);
`ifdef DRAM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 5; i++) begin
      gq.push_back(0);
      push_rsp(0, 1'b0, 4'hF);
    end
`else
    gq.push_back(0); push_rsp(0, 1'b0, 4'hF);
    gq.push_back(1); push_rsp(1, 1'b1, 4'h0);
    gq.push_back(2); push_rsp(2, 1'b0, 4'h3);
    gq.push_back(3); push_rsp(3, 1'b0, 4'h5);
    gq.push_back(0); push_rsp(0, 1'b0, 4'hF);
`endif
    for (int i = 0; i < 300 && gq.size() > 0; i++) step();
    chk("rr_all_grants_seen", 32'(gq.size()), 32'(0));
    req_valid = '0;
    keep_mask = '0;
    wait_drain("rr_drain");

    // Reset during WAIT_DONE while the controller is still busy.
    m_lat = 10;
    set_req(1, 1'b0, 18'h01234, 4'h0);
    gq.push_back(1);
    step();
    step();
    step();
    chk("rst_pre_busy", 32'({mem_busy, mem_ena}), 32'({1'b1, 1'b0}));
    rst = 1'b1;
    set_req(3, 1'b0, 18'h0ABCD, 4'h0);
    step();
    chk("rst_ctrl_outputs", 32'({mem_addr, mem_write, mem_ena, mem_wdata, mem_wdata_oe}), 32'(0));
    chk("rst_port_outputs", 32'({req_ready, rsp_valid, rsp_rdata}), 32'(0));
    rst = 1'b0;
    last_rd = '0; outstanding = 1'b0;
    gq.push_back(3);
    push_rsp(3, 1'b0, 4'h1);
    for (int i = 0; i < 100 && gq.size() > 0; i++) step();
    chk("rst_regrant_seen", 32'(gq.size()), 32'(0));
    chk("rst_no_issue_while_busy", 32'(grant_edge_busy), 32'(0));
    wait_drain("rst_drain");
    m_lat = 2;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dram_port_arbiter.md
Name: dram_port_arbiter

Overview:
- Shares the single HM515264 DRAM controller (one 18-bit address, 4-bit data access at a time) between NREQ requesters, e.g. CPU, video fetch and DMA.
- Selects one pending request, drives the controller's addr/write/ena handshake and holds write data on the DQ driver.
- Reports completion and read data back to the winning port.
- Sits between the requester fabric and the DRAM controller; refresh remains the controller's job.

Parameters:
- NREQ, 4: number of requester ports (2..8).
- AW, 18: address width.
- DW, 4: data width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NREQ  per-port request pending; held until req_ready.
- req_write  in  NREQ  per-port 1=write, 0=read.
- req_addr  in  NREQ*AW  per-port address; port i occupies bits [i*AW +: AW].
- req_wdata  in  NREQ*DW  per-port write data; port i occupies bits [i*DW +: DW].
- req_ready  out  NREQ  one-hot, 1-cycle pulse: request captured.
- rsp_valid  out  NREQ  one-hot, 1-cycle pulse: access complete.
- rsp_rdata  out  DW  read data, valid with rsp_valid for reads.
- mem_addr  out  AW  to controller addr.
- mem_write  out  1  to controller write.
- mem_ena  out  1  to controller ena.
- mem_busy  in  1  controller busy (not idle).
- mem_ack  in  1  controller ack.
- mem_rd_data  in  DW  controller latched read data.
- mem_wdata  out  DW  write data to DQ tristate driver.
- mem_wdata_oe  out  1  DQ output enable.

Behaviour:
- Reset: all outputs 0, state IDLE, rr_ptr = NREQ-1 (port 0 wins first). The controller has no reset; an access in flight at reset finishes unreported, and IDLE will not issue until mem_busy=0.
- Four states: IDLE, ISSUE, WAIT_DONE, DONE.
- IDLE: if mem_busy=0 and any req_valid:
  - pick winner g (see arbitration);
  - register addr/write/wdata of g into mem_addr/mem_write/mem_wdata;
  - set mem_ena=1 and mem_wdata_oe=req_write[g];
  - pulse req_ready[g] next cycle; go to ISSUE.
  - Minimum latency from req_valid to req_ready is 1 cycle.
- ISSUE:
  - Hold mem_ena=1 and all mem_* outputs stable.
  - Acceptance means mem_busy=1 AND mem_ack=1 in the same cycle. The controller keeps a stale ack=1 while idle after an access and shows busy=1/ack=0 while refreshing; neither counts as acceptance.
  - On acceptance: mem_ena<=0, go to WAIT_DONE.
  - Waiting through a refresh is unbounded, so there is no timeout.
- WAIT_DONE:
  - mem_addr, mem_write and mem_wdata stay stable; mem_wdata_oe stays as set.
  - On mem_busy=0: capture rsp_rdata<=mem_rd_data (reads only; writes leave rsp_rdata unchanged), pulse rsp_valid[g], clear mem_wdata_oe, go to DONE.
- DONE: one cycle, then return to IDLE. This guarantees one idle cycle for the controller between accesses.
- Arbitration (round-robin, default):
  - Search ports rr_ptr+1, rr_ptr+2, ... modulo NREQ; the first with req_valid wins.
  - rr_ptr<=g at grant time.
  - The ports requesting at the moment of grant are all served before any of them is served twice.
- Only one access is outstanding at a time. req_valid on other ports during an access is ignored until the next IDLE.
- A requester must not change addr/write/wdata while req_valid=1 and before req_ready. It may deassert req_valid the cycle after req_ready.
- Simultaneous requests: exactly one grant per IDLE visit. rsp_valid and req_ready are never asserted in the same cycle.
- rst asserted mid-access: immediate return to IDLE with outputs cleared; any pending rsp is dropped.

Optional Feature:
- Macro DRAM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; rr_ptr is removed. Port 0 (e.g. video) can starve the others.
- Undefined: round-robin as above.

Test Plan:
- Single read, port 2, addr 18'h1A5F3, controller model returns 4'hC → req_ready[2] 1 cycle after req_valid; mem_ena held until busy&ack; rsp_valid=4'b0100 with rsp_rdata=4'hC the cycle after busy falls.
- Single write, port 0, addr 18'h00010, wdata 4'h5 → mem_write=1 and mem_wdata_oe=1 with mem_wdata=4'h5 from ISSUE until done; rsp_valid[0] pulses; rsp_rdata unchanged.
- All 4 ports request continuously from reset → grant order 0,1,2,3,0; exactly one rsp per access; no req_ready overlaps an in-flight access. With DRAM_ARB_FIXED_PRIO_EN, every grant goes to port 0.
- Refresh collision: controller goes busy with ack=0 (refresh) the cycle ena rises → stays in ISSUE through refresh; accepts only on busy=1, ack=1; data correct.
- Stale ack: previous access ends with mem_ack still 1 and mem_busy=0, new request issued → arbiter does not leave ISSUE until mem_busy=1.
- rst pulsed during WAIT_DONE with mem_busy=1 → outputs 0 next cycle, no rsp_valid; a new request is not issued until mem_busy=0.
